// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core back end.
//   WB_SEL_*  : write-back result source select codes
//   F3_*      : load funct3 encodings
//   wb_state_e: write-back stage FSM encoding
package npc_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitMem = 2'd1,
        StCommit  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_ext.sv
// Load data extraction: shifts the addressed bytes of an aligned doubleword down to bit 0
// and sign- or zero-extends them according to funct3.
//   rdata   in  XLEN  aligned doubleword from memory
//   funct3  in  3     load type
//   addr_lo in  3     byte offset within the doubleword
//   data    out XLEN  extended load result
//   err     out 1     misaligned access or illegal funct3
module load_ext
    import npc_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr_lo,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic [XLEN-1:0] sh;

    always_comb begin
        sh   = rdata >> {addr_lo, 3'b000};
        data = '0;
        err  = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){sh[7]}}, sh[7:0]};
            F3_LH: begin
                data = {{(XLEN-16){sh[15]}}, sh[15:0]};
                err  = addr_lo[0];
            end
            F3_LW: begin
                data = {{(XLEN-32){sh[31]}}, sh[31:0]};
                err  = |addr_lo[1:0];
            end
            F3_LD: begin
                data = sh;
                err  = |addr_lo;
            end
            F3_LBU: data = {{(XLEN-8){1'b0}}, sh[7:0]};
            F3_LHU: begin
                data = {{(XLEN-16){1'b0}}, sh[15:0]};
                err  = addr_lo[0];
            end
            F3_LWU: begin
                data = {{(XLEN-32){1'b0}}, sh[31:0]};
                err  = |addr_lo[1:0];
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: accepts one retiring instruction per handshake, waits for load data when
// needed, and drives the register file write port (registered) for one cycle per instruction.
//   clk, rst                 clock; synchronous active-low reset
//   in_valid/in_ready        upstream handshake
//   in_rd, in_wen, in_sel    destination, write enable, result source
//   in_alu, in_pc4           non-load result candidates
//   in_funct3, in_addr_lo    load type and byte offset
//   mem_rvalid, mem_rdata    load response
//   RD, RD_Back, Control     register file write index/data/enable
//   fwd_valid/rd/data        forwarding copy of the write port
//   retire                   one pulse per completed instruction
//   err_timeout/err_misalign sticky error flags
module wb_stage
    import npc_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    input  logic [1:0]      in_sel,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [2:0]      in_funct3,
    input  logic [2:0]      in_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [4:0]      RD,
    output logic [XLEN-1:0] RD_Back,
    output logic            Control,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            retire,
    output logic            err_timeout,
    output logic            err_misalign
);

    wb_state_e       state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [4:0]      rd_q;
    logic            wen_q;
    logic [2:0]      funct3_q;
    logic [2:0]      addr_q;

    logic [4:0]      rd_out_d;
    logic [XLEN-1:0] data_out_d;
    logic            ctrl_d, retire_d, err_to_d, err_mis_d;
    logic [XLEN-1:0] direct_data;
    logic [XLEN-1:0] ext_data;
    logic            ext_err;
    logic            accept;

    assign in_ready = (state_q != StWaitMem);
    assign accept   = in_valid & in_ready;

    assign fwd_valid = Control;
    assign fwd_rd    = RD;
    assign fwd_data  = RD_Back;

    // Reserved select commits zero.
    always_comb begin
        case (in_sel)
            WB_SEL_ALU: direct_data = in_alu;
            WB_SEL_PC4: direct_data = in_pc4;
            default:    direct_data = '0;
        endcase
    end

    // Extraction works on the captured load fields, so upstream can move on during the wait.
    load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .rdata  (mem_rdata),
        .funct3 (funct3_q),
        .addr_lo(addr_q),
        .data   (ext_data),
        .err    (ext_err)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_d     = 1'b0;
        retire_d   = 1'b0;
        rd_out_d   = RD;
        data_out_d = RD_Back;
        err_to_d   = err_timeout;
        err_mis_d  = err_misalign;
        case (state_q)
            StIdle, StCommit: begin
                if (accept) begin
                    if (in_sel == WB_SEL_LOAD) begin
                        state_d = StWaitMem;
                        cnt_d   = '0;
                    end else begin
                        // Non-loads commit straight from the accept edge.
                        state_d  = StCommit;
                        retire_d = 1'b1;
                        if (in_wen && in_rd != 5'd0) begin
                            ctrl_d     = 1'b1;
                            rd_out_d   = in_rd;
                            data_out_d = direct_data;
                        end
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWaitMem: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    state_d  = StCommit;
                    retire_d = 1'b1;
                    if (ext_err) begin
                        err_mis_d = 1'b1;
                    end else if (wen_q && rd_q != 5'd0) begin
                        ctrl_d     = 1'b1;
                        rd_out_d   = rd_q;
                        data_out_d = ext_data;
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d  = StCommit;
                    retire_d = 1'b1;
                    err_to_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rd_q         <= '0;
            wen_q        <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            RD           <= '0;
            RD_Back      <= '0;
            Control      <= 1'b0;
            retire       <= 1'b0;
            err_timeout  <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            RD           <= rd_out_d;
            RD_Back      <= data_out_d;
            Control      <= ctrl_d;
            retire       <= retire_d;
            err_timeout  <= err_to_d;
            err_misalign <= err_mis_d;
            if (accept) begin
                rd_q     <= in_rd;
                wen_q    <= in_wen;
                funct3_q <= in_funct3;
                addr_q   <= in_addr_lo;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [1:0]  in_sel;
    logic [63:0] in_alu;
    logic [63:0] in_pc4;
    logic [2:0]  in_funct3;
    logic [2:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic [4:0]  RD;
    logic [63:0] RD_Back;
    logic        Control;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        retire;
    logic        err_timeout;
    logic        err_misalign;

    int total = 0;
    int bad   = 0;

    logic [4:0]  last_rd;
    logic [63:0] last_data;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_wen      (in_wen),
        .in_sel      (in_sel),
        .in_alu      (in_alu),
        .in_pc4      (in_pc4),
        .in_funct3   (in_funct3),
        .in_addr_lo  (in_addr_lo),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .RD          (RD),
        .RD_Back     (RD_Back),
        .Control     (Control),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .retire      (retire),
        .err_timeout (err_timeout),
        .err_misalign(err_misalign)
    );

    typedef struct {
        string       name;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] alu;
        logic [63:0] pc4;
        logic [2:0]  f3;
        logic [2:0]  lo;
        logic [63:0] rdata;
        int          dly;
        logic        exp_ctrl;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        last_rd = '0;
        last_data = '0;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic wen,
                         input logic [63:0] alu, input logic [63:0] pc4, input logic [2:0] f3,
                         input logic [2:0] lo);
        in_valid   = 1'b1;
        in_sel     = sel;
        in_rd      = rd;
        in_wen     = wen;
        in_alu     = alu;
        in_pc4     = pc4;
        in_funct3  = f3;
        in_addr_lo = lo;
    endtask

    // Applies one vector from idle and checks the commit cycle and the cycle after it.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v.sel, v.rd, v.wen, v.alu, v.pc4, v.f3, v.lo);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (v.sel == WB_SEL_LOAD) begin
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk);
                chk({v.name, " ready_low"}, 64'(in_ready), 64'd0);
                chk({v.name, " no_early_ctrl"}, 64'(Control), 64'd0);
            end
            mem_rdata  = v.rdata;
            mem_rvalid = 1'b1;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
        end
        if (v.exp_ctrl) begin
            last_rd   = v.rd;
            last_data = v.exp_data;
        end
        chk({v.name, " ctrl"}, 64'(Control), 64'(v.exp_ctrl));
        chk({v.name, " retire"}, 64'(retire), 64'd1);
        chk({v.name, " rd"}, 64'(RD), 64'(last_rd));
        chk({v.name, " data"}, RD_Back, last_data);
        chk({v.name, " fwd_valid"}, 64'(fwd_valid), 64'(v.exp_ctrl));
        chk({v.name, " fwd_rd"}, 64'(fwd_rd), 64'(last_rd));
        chk({v.name, " fwd_data"}, fwd_data, last_data);
        chk({v.name, " no_misalign"}, 64'(err_misalign), 64'd0);
        @(posedge clk);
        #1;
        chk({v.name, " ctrl_one_cycle"}, 64'(Control), 64'd0);
        chk({v.name, " retire_one_cycle"}, 64'(retire), 64'd0);
        chk({v.name, " data_hold"}, RD_Back, last_data);
    endtask

    initial begin
        logic [4:0]  b2b_rd [5];
        logic        b2b_ctl[5];
        int          k;
        bit          seen;

        vecs[0]  = '{"alu",   WB_SEL_ALU,  5'd5, 1'b1, 64'h1234, 64'h0, 3'd0, 3'd0, 64'h0, 0,
                     1'b1, 64'h1234};
        vecs[1]  = '{"pc4",   WB_SEL_PC4,  5'd1, 1'b1, 64'hAAAA, 64'h8000_0004, 3'd0, 3'd0, 64'h0,
                     0, 1'b1, 64'h8000_0004};
        vecs[2]  = '{"lb",    WB_SEL_LOAD, 5'd2, 1'b1, 64'h0, 64'h0, F3_LB, 3'd7,
                     64'h80FF_0000_0000_0000, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[3]  = '{"lbu",   WB_SEL_LOAD, 5'd3, 1'b1, 64'h0, 64'h0, F3_LBU, 3'd7,
                     64'h80FF_0000_0000_0000, 1, 1'b1, 64'h80};
        vecs[4]  = '{"lw",    WB_SEL_LOAD, 5'd4, 1'b1, 64'h0, 64'h0, F3_LW, 3'd4,
                     64'hDEAD_BEEF_0000_0000, 3, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF};
        vecs[5]  = '{"lwu",   WB_SEL_LOAD, 5'd6, 1'b1, 64'h0, 64'h0, F3_LWU, 3'd4,
                     64'hDEAD_BEEF_0000_0000, 3, 1'b1, 64'h0000_0000_DEAD_BEEF};
        vecs[6]  = '{"lh",    WB_SEL_LOAD, 5'd8, 1'b1, 64'h0, 64'h0, F3_LH, 3'd2,
                     64'h0000_0000_8001_0000, 2, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
        vecs[7]  = '{"lhu",   WB_SEL_LOAD, 5'd9, 1'b1, 64'h0, 64'h0, F3_LHU, 3'd6,
                     64'h1234_0000_0000_0000, 2, 1'b1, 64'h1234};
        vecs[8]  = '{"ld",    WB_SEL_LOAD, 5'd10, 1'b1, 64'h0, 64'h0, F3_LD, 3'd0,
                     64'h0123_4567_89AB_CDEF, 1, 1'b1, 64'h0123_4567_89AB_CDEF};
        vecs[9]  = '{"nowen", WB_SEL_ALU,  5'd11, 1'b0, 64'h5555, 64'h0, 3'd0, 3'd0, 64'h0, 0,
                     1'b0, 64'h0};
        vecs[10] = '{"rsvd",  2'd3,        5'd7, 1'b1, 64'h9999, 64'h7777, 3'd0, 3'd0, 64'h0, 0,
                     1'b1, 64'h0};

        rst        = 1'b0;
        in_valid   = 1'b0;
        in_rd      = '0;
        in_wen     = 1'b0;
        in_sel     = '0;
        in_alu     = '0;
        in_pc4     = '0;
        in_funct3  = '0;
        in_addr_lo = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        last_rd    = '0;
        last_data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst RD", 64'(RD), 64'd0);
        chk("rst RD_Back", RD_Back, 64'd0);
        chk("rst Control", 64'(Control), 64'd0);
        chk("rst retire", 64'(retire), 64'd0);
        chk("rst err_timeout", 64'(err_timeout), 64'd0);
        chk("rst err_misalign", 64'(err_misalign), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back non-loads, rd=0 in the middle
        b2b_rd  = '{5'd1, 5'd2, 5'd0, 5'd3, 5'd4};
        b2b_ctl = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b2b ready", 64'(in_ready), 64'd1);
            drive(WB_SEL_ALU, b2b_rd[i], 1'b1, 64'(100 + i), 64'h0, 3'd0, 3'd0);
            @(posedge clk);
            #1;
            if (b2b_ctl[i]) begin
                last_rd   = b2b_rd[i];
                last_data = 64'(100 + i);
            end
            chk("b2b ctrl", 64'(Control), 64'(b2b_ctl[i]));
            chk("b2b retire", 64'(retire), 64'd1);
            chk("b2b rd", 64'(RD), 64'(last_rd));
            chk("b2b data", RD_Back, last_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b end ctrl", 64'(Control), 64'd0);
        chk("b2b end retire", 64'(retire), 64'd0);

        // Misaligned LH: retire without write, sticky flag
        @(negedge clk);
        drive(WB_SEL_LOAD, 5'd12, 1'b1, 64'h0, 64'h0, F3_LH, 3'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        chk("mis flag", 64'(err_misalign), 64'd1);
        chk("mis ctrl", 64'(Control), 64'd0);
        chk("mis retire", 64'(retire), 64'd1);
        chk("mis data_hold", RD_Back, last_data);
        repeat (3) @(posedge clk);
        #1;
        chk("mis sticky", 64'(err_misalign), 64'd1);
        do_reset();
        #1;
        chk("mis cleared", 64'(err_misalign), 64'd0);

        // Illegal funct3 also flags misalign
        @(negedge clk);
        drive(WB_SEL_LOAD, 5'd13, 1'b1, 64'h0, 64'h0, 3'b111, 3'd0);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        chk("ill flag", 64'(err_misalign), 64'd1);
        chk("ill ctrl", 64'(Control), 64'd0);
        chk("ill retire", 64'(retire), 64'd1);
        do_reset();

        // Timeout: no response, err after exactly TIMEOUT cycles in WAIT_MEM
        @(negedge clk);
        drive(WB_SEL_LOAD, 5'd14, 1'b1, 64'h0, 64'h0, F3_LD, 3'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        seen = 1'b0;
        while (k < 300 && !seen) begin
            @(posedge clk);
            #1;
            k++;
            if (err_timeout) seen = 1'b1;
        end
        chk("to seen", 64'(seen), 64'd1);
        chk("to cycles", 64'(k), 64'd255);
        chk("to ctrl", 64'(Control), 64'd0);
        chk("to retire", 64'(retire), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("to sticky", 64'(err_timeout), 64'd1);
        chk("to ready", 64'(in_ready), 64'd1);
        do_reset();
        #1;
        chk("to cleared", 64'(err_timeout), 64'd0);

        // Reset during WAIT_MEM drops the load; a late response is ignored
        @(negedge clk);
        drive(WB_SEL_LOAD, 5'd15, 1'b1, 64'h0, 64'h0, F3_LD, 3'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rstw waiting", 64'(in_ready), 64'd0);
        do_reset();
        mem_rdata  = 64'hCAFE;
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        chk("rstw ready", 64'(in_ready), 64'd1);
        chk("rstw ctrl", 64'(Control), 64'd0);
        chk("rstw retire", 64'(retire), 64'd0);
        chk("rstw data", RD_Back, 64'd0);
        @(posedge clk);
        #1;
        chk("rstw ctrl2", 64'(Control), 64'd0);
        chk("rstw retire2", 64'(retire), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
